// File: rtl/draw_cmd_engine_if.sv
// Controller-to-engine bundle: command code and sprite positions in, VGA pixel stream and status out.
interface draw_cmd_engine_if;
  logic [4:0] cmd;
  logic [7:0] paddle_x;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output cmd, paddle_x, ball_x, ball_y,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  cmd, paddle_x, ball_x, ball_y,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/draw_cmd_engine.sv
// Decodes controller draw codes into filled rectangles (brick, paddle, ball) and
// rasterises them one pixel per cycle onto the 160x120 VGA adapter.
//
// state | meaning
// IDLE  | waiting for a new, valid command code
// SETUP | one cycle: compute rectangle origin and size, clear pixel counters
// DRAW  | one pixel per cycle, row-major; off-screen pixels suppress plot
// DONE  | one cycle completion pulse
module draw_cmd_engine #(
  parameter int BRICK_X0  = 8,
  parameter int BRICK_Y0  = 10,
  parameter int BRICK_W   = 32,
  parameter int BRICK_H   = 6,
  parameter int BRICK_GAP = 4,
  parameter int PADDLE_Y  = 112,
  parameter int PADDLE_W  = 24,
  parameter int PADDLE_H  = 4,
  parameter int BALL_SZ   = 2
) (
  input logic          clk,
  input logic          resetn,
  draw_cmd_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  last_cmd;
  logic [4:0]  code_r;
  logic [7:0]  paddle_x_r;
  logic [7:0]  ball_x_r;
  logic [6:0]  ball_y_r;
  logic [2:0]  colour_r;
  logic [8:0]  x0_r, y0_r;
  logic [7:0]  w_r, h_r;
  logic [7:0]  cx, cy;
  logic [7:0]  x_hold;
  logic [6:0]  y_hold;

  logic        cmd_valid, accept, last_px;
  logic [8:0]  px, py;

  // Decode runs on the live cmd while idle (for the colour latch) and on the
  // latched code afterwards (for geometry in SETUP).
  logic [4:0]  code_sel;
  logic        dec_brick, dec_paddle, dec_erase;
  logic [3:0]  dec_idx;
  logic [2:0]  dec_colour;

  assign cmd_valid = (bus.cmd >= 5'd1) && (bus.cmd <= 5'd28);
  assign accept    = (state == S_IDLE) && cmd_valid && (bus.cmd != last_cmd);
  assign code_sel  = (state == S_IDLE) ? bus.cmd : code_r;

  always_comb begin
    dec_brick  = 1'b0;
    dec_paddle = 1'b0;
    dec_erase  = 1'b0;
    dec_idx    = 4'd0;
    dec_colour = 3'b000;
    if (code_sel >= 5'd1 && code_sel <= 5'd12) begin
      dec_brick = 1'b1;
      dec_idx   = 4'(code_sel - 5'd1);
    end else if (code_sel == 5'd13 || code_sel == 5'd14) begin
      dec_paddle = 1'b1;
      dec_erase  = (code_sel == 5'd13);
    end else if (code_sel == 5'd15 || code_sel == 5'd16) begin
      dec_erase  = (code_sel == 5'd15);
    end else begin
      dec_brick = 1'b1;
      dec_erase = 1'b1;
      dec_idx   = 4'(code_sel - 5'd17);
    end
    if (!dec_erase) begin
      if (dec_brick) begin
        case (dec_idx[3:2])
          2'd0:    dec_colour = 3'b100;
          2'd1:    dec_colour = 3'b010;
          default: dec_colour = 3'b001;
        endcase
      end else if (dec_paddle) begin
        dec_colour = 3'b111;
      end else begin
        dec_colour = 3'b110;
      end
    end
  end

  assign px      = x0_r + {1'b0, cx};
  assign py      = y0_r + {1'b0, cy};
  assign last_px = (cx == w_r - 8'd1) && (cy == h_r - 8'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_DRAW;
      S_DRAW:  if (last_px) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state == S_SETUP) || (state == S_DRAW);
    bus.done   = (state == S_DONE);
    bus.plot   = (state == S_DRAW) && (px <= 9'd159) && (py <= 9'd119);
    bus.colour = (state == S_DRAW) ? colour_r : 3'b000;
    bus.x      = (state == S_DRAW) ? px[7:0] : x_hold;
    bus.y      = (state == S_DRAW) ? py[6:0] : y_hold;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_cmd   <= 5'd0;
      code_r     <= 5'd0;
      paddle_x_r <= 8'd0;
      ball_x_r   <= 8'd0;
      ball_y_r   <= 7'd0;
      colour_r   <= 3'b000;
      x0_r       <= 9'd0;
      y0_r       <= 9'd0;
      w_r        <= 8'd0;
      h_r        <= 8'd0;
      cx         <= 8'd0;
      cy         <= 8'd0;
      x_hold     <= 8'd0;
      y_hold     <= 7'd0;
    end else begin
      if (bus.cmd == 5'd0)  last_cmd <= 5'd0;
      else if (accept)      last_cmd <= bus.cmd;
      if (accept) begin
        code_r     <= bus.cmd;
        paddle_x_r <= bus.paddle_x;
        ball_x_r   <= bus.ball_x;
        ball_y_r   <= bus.ball_y;
        colour_r   <= dec_colour;
      end
      case (state)
        S_SETUP: begin
          cx <= 8'd0;
          cy <= 8'd0;
          if (dec_brick) begin
            x0_r <= 9'(BRICK_X0) + 9'(dec_idx[1:0]) * 9'(BRICK_W + BRICK_GAP);
            y0_r <= 9'(BRICK_Y0) + 9'(dec_idx[3:2]) * 9'(BRICK_H + BRICK_GAP);
            w_r  <= 8'(BRICK_W);
            h_r  <= 8'(BRICK_H);
          end else if (dec_paddle) begin
            x0_r <= {1'b0, paddle_x_r};
            y0_r <= 9'(PADDLE_Y);
            w_r  <= 8'(PADDLE_W);
            h_r  <= 8'(PADDLE_H);
          end else begin
            x0_r <= {1'b0, ball_x_r};
            y0_r <= {2'b00, ball_y_r};
            w_r  <= 8'(BALL_SZ);
            h_r  <= 8'(BALL_SZ);
          end
        end
        S_DRAW: begin
          x_hold <= px[7:0];
          y_hold <= py[6:0];
          if (cx == w_r - 8'd1) begin
            cx <= 8'd0;
            cy <= cy + 8'd1;
          end else begin
            cx <= cx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
